// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap-state holder.
// Sits behind the execute stage: takes its registered CSR writeback and
// trap/mret events, returns mepc/mtvec, and serves decode a combinational
// read port.
// Build option: define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret
// counters; without it the counter addresses read 0 and ignore writes.
module csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [XLEN-1:0] HART_ID   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     csr_rd_adr_i,
  input  logic            csr_rd_we_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_illegal_o,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      core_mode_i,
  input  logic            mret_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] mepc_q_o,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic [XLEN-1:0] mstatus_q_o
);

  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVAL     = 12'h343;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;

  localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;

  // Only the writable mstatus fields are stored; the rest are hardwired 0.
  logic            mie_q;
  logic            mpie_q;
  logic [1:0]      mpp_q;
  logic [XLEN-1:2] mtvec_q;
  logic [XLEN-1:2] mepc_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;
  logic [XLEN-1:0] rd_data;
  logic            rd_impl;
  logic            unused_mepc_lsb;

  // mepc is word aligned, so the low bits of the trap PC are discarded.
  assign unused_mepc_lsb = ^mepc_i[1:0];

  // Trap state and plain CSRs; trap beats mret beats software write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b11;
      mtvec_q    <= MTVEC_RST[XLEN-1:2];
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (exception_i) begin
      mepc_q   <= mepc_i[XLEN-1:2];
      mcause_q <= mcause_i;
      mtval_q  <= mtval_i;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      mpp_q    <= core_mode_i;
    end else if (mret_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
      mpp_q  <= 2'b00;
    end else if (csr_wbk_v_i) begin
      case (csr_adr_i)
        ADR_MSTATUS: begin
          mie_q  <= csr_data_i[3];
          mpie_q <= csr_data_i[7];
          // Only U (00) and M (11) exist; other encodings leave MPP alone.
          if (csr_data_i[12:11] == 2'b00 || csr_data_i[12:11] == 2'b11)
            mpp_q <= csr_data_i[12:11];
        end
        ADR_MTVEC:    mtvec_q    <= csr_data_i[XLEN-1:2];
        ADR_MSCRATCH: mscratch_q <= csr_data_i;
        ADR_MEPC:     mepc_q     <= csr_data_i[XLEN-1:2];
        ADR_MCAUSE:   mcause_q   <= csr_data_i;
        ADR_MTVAL:    mtval_q    <= csr_data_i;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic cnt_wr;

  // A counter write loses to a trap or mret in the same cycle, like any CSR write.
  assign cnt_wr = csr_wbk_v_i & ~exception_i & ~mret_i;

  // Free-running counters; a write to either half replaces that cycle's increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (cnt_wr && csr_adr_i == ADR_MCYCLE)
        mcycle_q[31:0] <= csr_data_i[31:0];
      else if (cnt_wr && csr_adr_i == ADR_MCYCLEH)
        mcycle_q[63:32] <= csr_data_i[31:0];
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (cnt_wr && csr_adr_i == ADR_MINSTRET)
        minstret_q[31:0] <= csr_data_i[31:0];
      else if (cnt_wr && csr_adr_i == ADR_MINSTRETH)
        minstret_q[63:32] <= csr_data_i[31:0];
      else if (instret_i)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_instret;

  assign unused_instret = instret_i;
  assign mcycle_q       = '0;
  assign minstret_q     = '0;
`endif

  assign mstatus_q_o = {{(XLEN-13){1'b0}}, mpp_q, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
  assign mtvec_q_o   = {mtvec_q, 2'b00};
  assign mepc_q_o    = {mepc_q, 2'b00};

  // Decode read port: straight mux of current state, no write bypass.
  always_comb begin
    rd_data = '0;
    rd_impl = 1'b1;
    case (csr_rd_adr_i)
      ADR_MSTATUS:   rd_data = mstatus_q_o;
      ADR_MISA:      rd_data = MISA_VAL;
      ADR_MTVEC:     rd_data = mtvec_q_o;
      ADR_MSCRATCH:  rd_data = mscratch_q;
      ADR_MEPC:      rd_data = mepc_q_o;
      ADR_MCAUSE:    rd_data = mcause_q;
      ADR_MTVAL:     rd_data = mtval_q;
      ADR_MHARTID:   rd_data = HART_ID;
      ADR_MCYCLE:    rd_data = mcycle_q[31:0];
      ADR_MCYCLEH:   rd_data = mcycle_q[63:32];
      ADR_MINSTRET:  rd_data = minstret_q[31:0];
      ADR_MINSTRETH: rd_data = minstret_q[63:32];
      default:       rd_impl = 1'b0;
    endcase
  end

  assign csr_rd_data_o = rd_data;
  assign csr_illegal_o = ~rd_impl | (csr_rd_we_i & (csr_rd_adr_i[11:10] == 2'b11));

endmodule
